// File: rtl/semaforo_pkg.sv
// Shared definitions for the intersection sequencer and the per-lamp semaphore decoders.
package semaforo_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;
  localparam logic [1:0] LIGHT_OFF    = 2'b11;

  typedef enum logic [3:0] {
    ST_FLASH  = 4'd0,
    ST_MAIN_G = 4'd1,
    ST_MAIN_Y = 4'd2,
    ST_CLR_A  = 4'd3,
    ST_PED_G  = 4'd4,
    ST_CLR_P  = 4'd5,
    ST_SIDE_G = 4'd6,
    ST_SIDE_Y = 4'd7,
    ST_CLR_B  = 4'd8
  } state_t;

  typedef struct packed {
    logic [1:0] main_l;
    logic [1:0] side_l;
    logic [1:0] ped_l;
  } lights_t;

  // Light pattern for a state; anything unrecognised shows all red.
  function automatic lights_t lights_of(input state_t st, input logic flash_ph);
    lights_t l;
    l = '{LIGHT_RED, LIGHT_RED, LIGHT_RED};
    case (st)
      ST_MAIN_G: l.main_l = LIGHT_GREEN;
      ST_MAIN_Y: l.main_l = LIGHT_YELLOW;
      ST_SIDE_G: l.side_l = LIGHT_GREEN;
      ST_SIDE_Y: l.side_l = LIGHT_YELLOW;
      ST_PED_G:  l.ped_l  = LIGHT_GREEN;
      ST_FLASH: begin
        l.main_l = flash_ph ? LIGHT_OFF : LIGHT_YELLOW;
        l.side_l = flash_ph ? LIGHT_OFF : LIGHT_YELLOW;
      end
      default: l = '{LIGHT_RED, LIGHT_RED, LIGHT_RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/semaforo_ctrl_tick_timer.sv
// Loadable down-counter of ticks; flags zero so the sequencer knows the current phase has expired.
module tick_timer #(
  parameter int              CNT_W   = 4,
  parameter logic [CNT_W-1:0] RST_VAL = {CNT_W{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  input  logic             i_tick,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load wins over counting; the counter parks at zero until reloaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_tick && (r_cnt != {CNT_W{1'b0}})) begin
      r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/semaforo_ctrl.sv
// Intersection sequencer: main road, side road and a latched pedestrian phase, with flashing-yellow mode.
module semaforo_ctrl
  import semaforo_pkg::*;
#(
  parameter int T_GREEN  = 8,
  parameter int T_YELLOW = 3,
  parameter int T_CLEAR  = 2,
  parameter int T_PED    = 6,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       tick,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic [1:0] light_main,
  output logic [1:0] light_side,
  output logic [1:0] light_ped
);

  localparam logic [CNT_W-1:0] D_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] D_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] D_CLEAR  = CNT_W'(T_CLEAR - 1);
  localparam logic [CNT_W-1:0] D_PED    = CNT_W'(T_PED - 1);

  state_t           r_state;
  logic             r_ped_pend;
  logic             r_ped_ack;
  logic             r_flash_ph;
  lights_t          r_lights;

  state_t           w_nxt;
  logic             w_zero;
  logic             w_adv;
  logic             w_load;
  logic             w_ped_entry;
  logic             w_flash_nxt;
  logic [CNT_W-1:0] w_dur;

  assign w_adv       = tick & w_zero;
  assign w_load      = (w_nxt != r_state);
  assign w_ped_entry = (w_nxt == ST_PED_G) && (r_state != ST_PED_G);

  // Next state: disabling forces FLASH immediately; otherwise phases advance only on an expiring tick.
  always_comb begin
    w_nxt = ST_CLR_B;
    if (!en) begin
      w_nxt = ST_FLASH;
    end else begin
      case (r_state)
        ST_FLASH:  w_nxt = ST_CLR_B;
        ST_MAIN_G: w_nxt = w_adv ? ST_MAIN_Y : ST_MAIN_G;
        ST_MAIN_Y: w_nxt = w_adv ? ST_CLR_A  : ST_MAIN_Y;
        ST_CLR_A:  w_nxt = w_adv ? (r_ped_pend ? ST_PED_G : ST_SIDE_G) : ST_CLR_A;
        ST_PED_G:  w_nxt = w_adv ? ST_CLR_P  : ST_PED_G;
        ST_CLR_P:  w_nxt = w_adv ? ST_SIDE_G : ST_CLR_P;
        ST_SIDE_G: w_nxt = w_adv ? ST_SIDE_Y : ST_SIDE_G;
        ST_SIDE_Y: w_nxt = w_adv ? ST_CLR_B  : ST_SIDE_Y;
        ST_CLR_B:  w_nxt = w_adv ? ST_MAIN_G : ST_CLR_B;
        default:   w_nxt = ST_CLR_B;
      endcase
    end
  end

  // Timer reload value for the state being entered.
  always_comb begin
    w_dur = {CNT_W{1'b0}};
    case (w_nxt)
      ST_MAIN_G, ST_SIDE_G:          w_dur = D_GREEN;
      ST_MAIN_Y, ST_SIDE_Y:          w_dur = D_YELLOW;
      ST_CLR_A, ST_CLR_P, ST_CLR_B:  w_dur = D_CLEAR;
      ST_PED_G:                      w_dur = D_PED;
      default:                       w_dur = {CNT_W{1'b0}};
    endcase
  end

  // Flash phase restarts at 0 on FLASH entry and toggles per tick while flashing.
  always_comb begin
    w_flash_nxt = 1'b0;
    if ((w_nxt == ST_FLASH) && (r_state == ST_FLASH)) begin
      w_flash_nxt = r_flash_ph ^ tick;
    end else begin
      w_flash_nxt = 1'b0;
    end
  end

  tick_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (D_CLEAR)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_value (w_dur),
    .i_tick  (tick),
    .o_zero  (w_zero)
  );

  // State, pedestrian latch and lights all update on the same edge, lights taken from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_CLR_B;
      r_ped_pend <= 1'b0;
      r_ped_ack  <= 1'b0;
      r_flash_ph <= 1'b0;
      r_lights   <= '{LIGHT_RED, LIGHT_RED, LIGHT_RED};
    end else begin
      r_state    <= w_nxt;
      r_flash_ph <= w_flash_nxt;
      r_ped_ack  <= w_ped_entry;
      r_lights   <= lights_of(w_nxt, w_flash_nxt);
      if (w_ped_entry) begin
        r_ped_pend <= 1'b0;
      end else if (ped_req && (r_state != ST_PED_G) && (r_state != ST_CLR_P)) begin
        r_ped_pend <= 1'b1;
      end else begin
        r_ped_pend <= r_ped_pend;
      end
    end
  end

  assign ped_ack    = r_ped_ack;
  assign light_main = r_lights.main_l;
  assign light_side = r_lights.side_l;
  assign light_ped  = r_lights.ped_l;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Directed bench for semaforo_ctrl: phase timing, pedestrian service, flashing mode, reset, random invariants.
module tb_semaforo_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic       ped_ack;
  logic [1:0] light_main;
  logic [1:0] light_side;
  logic [1:0] light_ped;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int ack_cnt = 0;
  int ack_base = 0;

  semaforo_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .tick       (tick),
    .ped_req    (ped_req),
    .ped_ack    (ped_ack),
    .light_main (light_main),
    .light_side (light_side),
    .light_ped  (light_ped)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ped_ack === 1'b1) ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_l(input string tag, input logic [1:0] m, input logic [1:0] s, input logic [1:0] p);
    chk(tag, {2'b00, light_main, light_side, light_ped}, {2'b00, m, s, p});
  endtask

  task automatic clk1(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      clk1(1'b0);
      clk1(1'b0);
      clk1(1'b0);
      clk1(1'b1);
    end
  endtask

  initial begin
    #1;
    chk_l("rst_lights", 2'b00, 2'b00, 2'b00);
    chk("rst_ack", {7'd0, ped_ack}, 8'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Plain cycle, no pedestrian
    ticks(1);  chk_l("t1_clrb_1", 2'b00, 2'b00, 2'b00);
    ticks(1);  chk_l("t1_main_g", 2'b10, 2'b00, 2'b00);
    ticks(7);  chk_l("t1_main_g_end", 2'b10, 2'b00, 2'b00);
    ticks(1);  chk_l("t1_main_y", 2'b01, 2'b00, 2'b00);
    ticks(2);  chk_l("t1_main_y_end", 2'b01, 2'b00, 2'b00);
    ticks(1);  chk_l("t1_clr_a", 2'b00, 2'b00, 2'b00);
    ticks(1);  chk_l("t1_clr_a_end", 2'b00, 2'b00, 2'b00);
    ticks(1);  chk_l("t1_side_g", 2'b00, 2'b10, 2'b00);
    ticks(7);  chk_l("t1_side_g_end", 2'b00, 2'b10, 2'b00);
    ticks(1);  chk_l("t1_side_y", 2'b00, 2'b01, 2'b00);
    ticks(2);  chk_l("t1_side_y_end", 2'b00, 2'b01, 2'b00);
    ticks(1);  chk_l("t1_clr_b", 2'b00, 2'b00, 2'b00);
    ticks(1);  chk_l("t1_clr_b_end", 2'b00, 2'b00, 2'b00);
    ticks(1);  chk_l("t1_main_g2", 2'b10, 2'b00, 2'b00);
    chk("t1_no_ack", 8'(ack_cnt), 8'd0);

    // Single-clock pedestrian pulse during MAIN_G
    ped_req = 1'b1; clk1(1'b0); ped_req = 1'b0;
    ticks(8);  chk_l("t2_main_y", 2'b01, 2'b00, 2'b00);
    ticks(3);  chk_l("t2_clr_a", 2'b00, 2'b00, 2'b00);
    ticks(2);  chk_l("t2_ped_g", 2'b00, 2'b00, 2'b10);
    chk("t2_ack_on", {7'd0, ped_ack}, 8'd1);
    clk1(1'b0);
    chk("t2_ack_off", {7'd0, ped_ack}, 8'd0);
    ticks(5);  chk_l("t2_ped_g_end", 2'b00, 2'b00, 2'b10);
    ticks(1);  chk_l("t2_clr_p", 2'b00, 2'b00, 2'b00);
    ticks(1);  chk_l("t2_clr_p_end", 2'b00, 2'b00, 2'b00);
    ticks(1);  chk_l("t2_side_g", 2'b00, 2'b10, 2'b00);
    chk("t2_ack_cnt", 8'(ack_cnt), 8'd1);

    // Request held across PED_G entry: served once only
    ticks(8 + 3 + 2 + 8 + 3);
    chk_l("t3_clr_a", 2'b00, 2'b00, 2'b00);
    ped_req = 1'b1;
    ticks(2);  chk_l("t3_ped_g", 2'b00, 2'b00, 2'b10);
    chk("t3_ack_on", {7'd0, ped_ack}, 8'd1);
    ticks(1);
    ped_req = 1'b0;
    ticks(5);  chk_l("t3_clr_p", 2'b00, 2'b00, 2'b00);
    ticks(2);  chk_l("t3_side_g", 2'b00, 2'b10, 2'b00);
    ticks(8 + 3 + 2 + 8 + 3 + 2);
    chk_l("t3_no_second_ped", 2'b00, 2'b10, 2'b00);
    chk("t3_ack_cnt", 8'(ack_cnt), 8'd2);

    // Flashing mode entered mid SIDE_G
    ticks(2);
    en = 1'b0; clk1(1'b0);
    chk_l("t4_flash_0", 2'b01, 2'b01, 2'b00);
    ticks(1);  chk_l("t4_flash_1", 2'b11, 2'b11, 2'b00);
    ticks(1);  chk_l("t4_flash_2", 2'b01, 2'b01, 2'b00);
    en = 1'b1; clk1(1'b0);
    chk_l("t4_clr_b", 2'b00, 2'b00, 2'b00);
    ticks(1);  chk_l("t4_clr_b_end", 2'b00, 2'b00, 2'b00);
    ticks(1);  chk_l("t4_main_g", 2'b10, 2'b00, 2'b00);

    // Asynchronous reset right after PED_G entry
    ped_req = 1'b1; clk1(1'b0); ped_req = 1'b0;
    ticks(8 + 3 + 2);
    chk_l("t5_ped_g", 2'b00, 2'b00, 2'b10);
    chk("t5_ack_on", {7'd0, ped_ack}, 8'd1);
    #2 reset = 1'b1;
    #1;
    chk_l("t5_rst_lights", 2'b00, 2'b00, 2'b00);
    chk("t5_rst_ack", {7'd0, ped_ack}, 8'd0);
    @(posedge clk); #1; reset = 1'b0;
    ticks(2);  chk_l("t5_main_g", 2'b10, 2'b00, 2'b00);

    // Pending request dropped by reset
    ped_req = 1'b1; clk1(1'b0); ped_req = 1'b0;
    ticks(3);
    #2 reset = 1'b1;
    #1;
    chk_l("t5b_rst_lights", 2'b00, 2'b00, 2'b00);
    @(posedge clk); #1; reset = 1'b0;
    ack_base = ack_cnt;
    ticks(2 + 8 + 3 + 2);
    chk_l("t5b_side_g", 2'b00, 2'b10, 2'b00);
    chk("t5b_no_ack", 8'(ack_cnt - ack_base), 8'd0);

    // Random stimulus with safety invariants
    for (int i = 0; i < 10000; i++) begin
      en      = ($urandom_range(0, 15) != 0);
      ped_req = ($urandom_range(0, 7) == 0);
      tick    = ($urandom_range(0, 2) == 0);
      @(posedge clk);
      #1;
      chk("rnd_two_green", {7'd0, (light_main == 2'b10) && (light_side == 2'b10)}, 8'd0);
      chk("rnd_ped_conflict",
          {7'd0, ((light_main == 2'b10) || (light_side == 2'b10)) && (light_ped == 2'b10)}, 8'd0);
    end
    en = 1'b1; ped_req = 1'b0; tick = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
